addr_lookup: RTL and testbench

//  Read side of the two-way hashed sva->spa address map. Accepts a lookup
//  for one sva and hashes it with both per-way universal hashes. Probes way 0,

---
 rtl/addr_map_pkg.sv | 40 ++++
 rtl/addr_lookup_if.sv | 41 ++++
 rtl/addr_hash_unit.sv | 35 +++
 rtl/addr_lookup.sv | 142 ++++++++++++++
 tb/tb_addr_lookup.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_map_pkg.sv
// Shared definitions for the two-way hashed sva->spa address map.
// Used by both the lookup (read) side and the insert (put) side so the two
// always agree on address width, state names and bucket hashing.
//   ADDR_WIDTH    : width of sva, spa and each hash coefficient
//   addr_bits     : one address / coefficient word
//   lookup_state_e: states of the lookup sequencer
//   default_hash  : universal hash of an sva into a bucket index of 'lg' bits
package addr_map_pkg;

    localparam int ADDR_WIDTH = 64;

    typedef logic [ADDR_WIDTH-1:0] addr_bits;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HASH,
        ST_RD0,
        ST_CHK0,
        ST_RD1,
        ST_CHK1,
        ST_RESP
    } lookup_state_e;

    // Split the sva into zero-extended halves, combine them with the way's
    // coefficients modulo 2^ADDR_WIDTH and keep the top 'lg' bits as the
    // bucket index (returned right-aligned in a full-width word).
    function automatic addr_bits default_hash(input addr_bits    sva,
                                              input addr_bits    a,
                                              input addr_bits    b,
                                              input int unsigned lg);
        addr_bits upper;
        addr_bits lower;
        addr_bits h;
        upper = {{(ADDR_WIDTH/2){1'b0}}, sva[ADDR_WIDTH-1:ADDR_WIDTH/2]};
        lower = {{(ADDR_WIDTH/2){1'b0}}, sva[ADDR_WIDTH/2-1:0]};
        h     = upper * a + lower * b;
        return h >> (ADDR_WIDTH - lg);
    endfunction

endpackage

// File: rtl/addr_lookup_if.sv
// Handshake and table-read bundle of the address-map lookup side.
//   req_* : lookup request (valid/ready plus the sva to look up)
//   rd_*  : table read strobe, way and bucket out; occupancy/key/value back
//           one cycle after the strobe
//   rsp_* : lookup response (valid/ready plus hit flag and spa)
// slave  : the lookup engine
// master : the requester / table model driving the other side
interface addr_lookup_if
    import addr_map_pkg::*;
#(
    parameter int ADDR_WIDTH = addr_map_pkg::ADDR_WIDTH,
    parameter int LG_BUCKETS = 2
);

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_sva;

    logic                  rd_en;
    logic                  rd_way;
    logic [LG_BUCKETS-1:0] rd_idx;
    logic                  rd_occ;
    logic [ADDR_WIDTH-1:0] rd_key;
    logic [ADDR_WIDTH-1:0] rd_val;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_hit;
    logic [ADDR_WIDTH-1:0] rsp_spa;

    modport slave (
        input  req_valid, req_sva, rd_occ, rd_key, rd_val, rsp_ready,
        output req_ready, rd_en, rd_way, rd_idx, rsp_valid, rsp_hit, rsp_spa
    );

    modport master (
        output req_valid, req_sva, rd_occ, rd_key, rd_val, rsp_ready,
        input  req_ready, rd_en, rd_way, rd_idx, rsp_valid, rsp_hit, rsp_spa
    );

endinterface

// File: rtl/addr_hash_unit.sv
// Computes the bucket index of an sva for both ways and registers them.
// Results appear one cycle after 'load' (the lookup's HASH cycle).
//   clk, rst_n   : clock, synchronous active-low reset
//   load         : capture new indices this cycle
//   sva          : address being looked up
//   coe_a, coe_b : {way1, way0} hash coefficients
//   idx0, idx1   : registered bucket indices for way 0 / way 1
module addr_hash_unit
    import addr_map_pkg::*;
#(
    parameter int LG_BUCKETS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  addr_bits                sva,
    input  logic [2*ADDR_WIDTH-1:0] coe_a,
    input  logic [2*ADDR_WIDTH-1:0] coe_b,
    output logic [LG_BUCKETS-1:0]   idx0,
    output logic [LG_BUCKETS-1:0]   idx1
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx0 <= '0;
            idx1 <= '0;
        end else if (load) begin
            idx0 <= LG_BUCKETS'(default_hash(sva, coe_a[ADDR_WIDTH-1:0],
                                             coe_b[ADDR_WIDTH-1:0], LG_BUCKETS));
            idx1 <= LG_BUCKETS'(default_hash(sva, coe_a[2*ADDR_WIDTH-1:ADDR_WIDTH],
                                             coe_b[2*ADDR_WIDTH-1:ADDR_WIDTH], LG_BUCKETS));
        end
    end

endmodule

// File: rtl/addr_lookup.sv
// Read side of the two-way hashed sva->spa address map. Takes one lookup at
// a time, hashes it for both ways, probes way 0 and only on a miss way 1,
// then presents hit/spa until the consumer takes it.
//   clk, rst_n         : clock, synchronous active-low reset
//   coe_a, coe_b       : {way1, way0} hash coefficients (shared with insert side)
//   bus                : request / table-read / response bundle (slave side)
//   hit_cnt, miss_cnt  : saturating counts of delivered hit / miss responses
module addr_lookup
    import addr_map_pkg::*;
#(
    parameter int LG_BUCKETS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*ADDR_WIDTH-1:0] coe_a,
    input  logic [2*ADDR_WIDTH-1:0] coe_b,
    addr_lookup_if.slave            bus,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);

    lookup_state_e           state;
    lookup_state_e           next_state;
    addr_bits                sva_q;
    logic [2*ADDR_WIDTH-1:0] coe_a_q;
    logic [2*ADDR_WIDTH-1:0] coe_b_q;
    logic [LG_BUCKETS-1:0]   idx0;
    logic [LG_BUCKETS-1:0]   idx1;
    logic [LG_BUCKETS-1:0]   idx_hold;
    logic                    way_hold;
    logic                    entry_hit;

    // An empty slot never matches, even if its stale key equals the sva.
    assign entry_hit = bus.rd_occ && (bus.rd_key == sva_q);

    addr_hash_unit #(.LG_BUCKETS(LG_BUCKETS)) u_hash (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == ST_HASH),
        .sva   (sva_q),
        .coe_a (coe_a_q),
        .coe_b (coe_b_q),
        .idx0  (idx0),
        .idx1  (idx1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Read way/index follow the live index during an RD cycle and keep the
    // last read's values otherwise, so the table sees a stable address.
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_way    = way_hold;
        bus.rd_idx    = idx_hold;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = ST_HASH;
                end
            end
            ST_HASH: next_state = ST_RD0;
            ST_RD0: begin
                bus.rd_en  = 1'b1;
                bus.rd_way = 1'b0;
                bus.rd_idx = idx0;
                next_state = ST_CHK0;
            end
            ST_CHK0: next_state = entry_hit ? ST_RESP : ST_RD1;
            ST_RD1: begin
                bus.rd_en  = 1'b1;
                bus.rd_way = 1'b1;
                bus.rd_idx = idx1;
                next_state = ST_CHK1;
            end
            ST_CHK1: next_state = ST_RESP;
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Coefficients are latched with the sva so later changes cannot disturb
    // a lookup in flight. Response fields only change in the CHK cycles, so
    // they stay put for the whole time the response is offered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sva_q       <= '0;
            coe_a_q     <= '0;
            coe_b_q     <= '0;
            idx_hold    <= '0;
            way_hold    <= 1'b0;
            bus.rsp_hit <= 1'b0;
            bus.rsp_spa <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                sva_q   <= bus.req_sva;
                coe_a_q <= coe_a;
                coe_b_q <= coe_b;
            end
            if (state == ST_RD0) begin
                way_hold <= 1'b0;
                idx_hold <= idx0;
            end
            if (state == ST_RD1) begin
                way_hold <= 1'b1;
                idx_hold <= idx1;
            end
            if (state == ST_CHK0 && entry_hit) begin
                bus.rsp_hit <= 1'b1;
                bus.rsp_spa <= bus.rd_val;
            end
            if (state == ST_CHK1) begin
                bus.rsp_hit <= entry_hit;
                bus.rsp_spa <= entry_hit ? bus.rd_val : '0;
            end
            if (state == ST_RESP && bus.rsp_ready) begin
                if (bus.rsp_hit) begin
                    if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_addr_lookup.sv
// Bench for addr_lookup: directed scenarios then randomized lookups.
// The requester side pushes the predicted response (and the table reads it
// should cause) into queues when a request is accepted; independent monitor
// processes pop and compare as the DUT produces reads and responses.
module tb_addr_lookup;

    localparam logic [127:0] STD_A   = {64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000};
    localparam logic [127:0] SWAP_A  = {64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000};
    localparam logic [63:0]  STD_SVA = 64'h0000_0001_0000_0000;

    typedef struct {
        logic        hit;
        logic [63:0] spa;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        int         edge_no;
        logic       way;
        logic [1:0] idx;
    } rd_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] coe_a;
    logic [127:0] coe_b;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           ready_policy = 0;

    exp_t         sb[$];
    rd_t          rdq[$];
    logic         rsp_open = 1'b0;
    logic         held_hit;
    logic [63:0]  held_spa;
    logic         prev_rst_low = 1'b1;
    logic [31:0]  model_hits = 0;
    logic [31:0]  model_misses = 0;
    int           acc_count = 0;
    int           last_acc_edge = 0;
    int           last_hs_edge = 0;

    logic         tbl_occ [2][4];
    logic [63:0]  tbl_key [2][4];
    logic [63:0]  tbl_val [2][4];

    exp_t         mon_e;
    int           mon_i0;
    int           mon_i1;
    rd_t          tbl_r;
    logic         tbl_way;
    logic [1:0]   tbl_idx;

    addr_lookup_if #(.ADDR_WIDTH(64), .LG_BUCKETS(2)) bus ();

    addr_lookup #(.LG_BUCKETS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .coe_a    (coe_a),
        .coe_b    (coe_b),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Bucket of an sva: top two bits of (upper_half*a + lower_half*b) mod 2^64.
    function automatic int tb_bucket(input logic [63:0] sva, input logic [63:0] a,
                                     input logic [63:0] b);
        logic [63:0] h;
        h = {32'd0, sva[63:32]} * a + {32'd0, sva[31:0]} * b;
        return int'(h[63:62]);
    endfunction

    // Response consumer readiness: 0 always ready, 1 random, 2 stalled.
    always @(posedge clk) begin
        #1;
        case (ready_policy)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'($urandom_range(0, 1));
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    // Table memory: answers a read strobe one cycle later and checks that
    // each read is one the reference model expected, at the expected edge.
    always @(negedge clk) begin
        if (bus.rd_en) begin
            tbl_way = bus.rd_way;
            tbl_idx = bus.rd_idx;
            if (rdq.size() == 0) begin
                check_output("read_expected", 64'(rdq.size() > 0), 64'd1);
            end else begin
                tbl_r = rdq.pop_front();
                check_output("read_edge", 64'(cyc + 1), 64'(tbl_r.edge_no));
                check_output("read_way", 64'(tbl_way), 64'(tbl_r.way));
                check_output("read_idx", 64'(tbl_idx), 64'(tbl_r.idx));
            end
            @(posedge clk);
            #1;
            bus.rd_occ = tbl_occ[tbl_way][tbl_idx];
            bus.rd_key = tbl_key[tbl_way][tbl_idx];
            bus.rd_val = tbl_val[tbl_way][tbl_idx];
        end
    end

    // Scoreboard: predicts on accept, compares on response.
    always @(negedge clk) begin
        if (prev_rst_low) begin
            sb.delete();
            rdq.delete();
            rsp_open     = 1'b0;
            model_hits   = 0;
            model_misses = 0;
            check_output("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check_output("rst_rd_en", 64'(bus.rd_en), 64'd0);
            check_output("rst_rd_way", 64'(bus.rd_way), 64'd0);
            check_output("rst_rd_idx", 64'(bus.rd_idx), 64'd0);
            check_output("rst_rsp_hit", 64'(bus.rsp_hit), 64'd0);
            check_output("rst_rsp_spa", bus.rsp_spa, 64'd0);
            check_output("rst_req_ready", 64'(bus.req_ready), 64'd1);
        end
        check_output("hit_cnt", 64'(hit_cnt), 64'(model_hits));
        check_output("miss_cnt", 64'(miss_cnt), 64'(model_misses));
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) begin
                mon_i0 = tb_bucket(bus.req_sva, coe_a[63:0], coe_b[63:0]);
                mon_i1 = tb_bucket(bus.req_sva, coe_a[127:64], coe_b[127:64]);
                mon_e.acc = cyc + 1;
                rdq.push_back('{cyc + 3, 1'b0, 2'(mon_i0)});
                if (tbl_occ[0][mon_i0] && tbl_key[0][mon_i0] == bus.req_sva) begin
                    mon_e.hit = 1'b1;
                    mon_e.spa = tbl_val[0][mon_i0];
                    mon_e.lat = 4;
                end else begin
                    rdq.push_back('{cyc + 5, 1'b1, 2'(mon_i1)});
                    mon_e.lat = 6;
                    if (tbl_occ[1][mon_i1] && tbl_key[1][mon_i1] == bus.req_sva) begin
                        mon_e.hit = 1'b1;
                        mon_e.spa = tbl_val[1][mon_i1];
                    end else begin
                        mon_e.hit = 1'b0;
                        mon_e.spa = 64'd0;
                    end
                end
                sb.push_back(mon_e);
                last_acc_edge = cyc + 1;
                acc_count++;
            end
            if (bus.rsp_valid) begin
                if (!rsp_open) begin
                    rsp_open = 1'b1;
                    held_hit = bus.rsp_hit;
                    held_spa = bus.rsp_spa;
                    if (sb.size() == 0) begin
                        check_output("rsp_expected", 64'(sb.size() > 0), 64'd1);
                    end else begin
                        check_output("rsp_latency", 64'(cyc + 1 - sb[0].acc), 64'(sb[0].lat));
                    end
                end else begin
                    check_output("rsp_hit_stable", 64'(bus.rsp_hit), 64'(held_hit));
                    check_output("rsp_spa_stable", bus.rsp_spa, held_spa);
                end
                check_output("req_ready_busy", 64'(bus.req_ready), 64'd0);
                if (bus.rsp_ready) begin
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check_output("rsp_hit", 64'(bus.rsp_hit), 64'(mon_e.hit));
                        check_output("rsp_spa", bus.rsp_spa, mon_e.spa);
                        if (mon_e.hit) begin
                            if (model_hits != 32'hFFFF_FFFF) model_hits = model_hits + 1;
                        end else begin
                            if (model_misses != 32'hFFFF_FFFF) model_misses = model_misses + 1;
                        end
                    end
                    rsp_open     = 1'b0;
                    last_hs_edge = cyc + 1;
                end
            end
        end
        prev_rst_low = !rst_n;
    end

    task automatic clear_table();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) begin
                tbl_occ[w][i] = 1'b0;
                tbl_key[w][i] = 64'd0;
                tbl_val[w][i] = 64'd0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] sva, input logic hold);
        logic accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_sva   = sva;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check_output("accept_timeout", 64'(accepted), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_open && bus.req_ready) begin
                done = 1'b1;
                break;
            end
        end
        check_output("idle_timeout", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic load_test2_table();
        clear_table();
        tbl_occ[0][1] = 1'b1;
        tbl_key[0][1] = STD_SVA;
        tbl_val[0][1] = 64'hDEAD_BEEF_0000_1000;
    endtask

    initial begin
        logic  got;
        int    t;
        int    base;
        int    i0;
        int    i1;
        logic [63:0] sva;

        bus.req_valid = 1'b0;
        bus.req_sva   = 64'd0;
        bus.rd_occ    = 1'b0;
        bus.rd_key    = 64'd0;
        bus.rd_val    = 64'd0;
        bus.rsp_ready = 1'b1;
        coe_a = STD_A;
        coe_b = 128'd0;
        clear_table();

        $display("[TB] test 1: reset");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("ready_after_reset", 64'(bus.req_ready), 64'd1);

        $display("[TB] test 2: way0 hit");
        load_test2_table();
        apply_stimulus(STD_SVA, 1'b0);
        wait_idle();
        check_output("t2_hit_cnt", 64'(hit_cnt), 64'd1);
        check_output("t2_miss_cnt", 64'(miss_cnt), 64'd0);

        $display("[TB] test 3: way1 hit");
        clear_table();
        tbl_occ[0][1] = 1'b1;
        tbl_key[0][1] = 64'd0;
        tbl_val[0][1] = 64'h5555;
        tbl_occ[1][3] = 1'b1;
        tbl_key[1][3] = STD_SVA;
        tbl_val[1][3] = 64'h1234;
        apply_stimulus(STD_SVA, 1'b0);
        wait_idle();
        check_output("t3_hit_cnt", 64'(hit_cnt), 64'd2);

        $display("[TB] test 4: unoccupied entries with matching keys");
        clear_table();
        tbl_key[0][1] = STD_SVA;
        tbl_val[0][1] = 64'h7777;
        tbl_key[1][3] = STD_SVA;
        tbl_val[1][3] = 64'h8888;
        apply_stimulus(STD_SVA, 1'b0);
        wait_idle();
        check_output("t4_miss_cnt", 64'(miss_cnt), 64'd1);
        check_output("t4_hit_cnt", 64'(hit_cnt), 64'd2);

        $display("[TB] test 5: response stall, coefficient change, back-to-back");
        load_test2_table();
        ready_policy = 2;
        base = acc_count;
        apply_stimulus(STD_SVA, 1'b1);
        @(posedge clk);
        #1;
        coe_a = SWAP_A;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_output("t5_rsp_timeout", 64'(got), 64'd1);
        repeat (5) @(posedge clk);
        ready_policy = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_count >= base + 2) begin
                got = 1'b1;
                break;
            end
        end
        check_output("t5_second_accept", 64'(got), 64'd1);
        check_output("t5_next_accept_edge", 64'(last_acc_edge), 64'(last_hs_edge + 1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wait_idle();
        coe_a = STD_A;
        check_output("t5_hit_cnt", 64'(hit_cnt), 64'd3);
        check_output("t5_miss_cnt", 64'(miss_cnt), 64'd2);

        $display("[TB] test 6: reset during lookup");
        load_test2_table();
        apply_stimulus(STD_SVA, 1'b0);
        t = last_acc_edge;
        for (int i = 0; i < 10 && cyc < t + 2; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_output("t6_hit_cnt_after_abort", 64'(hit_cnt), 64'd0);
        check_output("t6_rsp_valid_after_abort", 64'(bus.rsp_valid), 64'd0);
        apply_stimulus(STD_SVA, 1'b0);
        wait_idle();
        check_output("t6_hit_cnt_after_retry", 64'(hit_cnt), 64'd1);

        $display("[TB] random lookups");
        ready_policy = 1;
        for (int n = 0; n < 40; n++) begin
            coe_a = {$urandom, $urandom, $urandom, $urandom};
            coe_b = {$urandom, $urandom, $urandom, $urandom};
            sva   = {$urandom, $urandom};
            for (int w = 0; w < 2; w++) begin
                for (int i = 0; i < 4; i++) begin
                    tbl_occ[w][i] = 1'($urandom_range(0, 1));
                    tbl_key[w][i] = {$urandom, $urandom};
                    tbl_val[w][i] = {$urandom, $urandom};
                end
            end
            i0 = tb_bucket(sva, coe_a[63:0], coe_b[63:0]);
            i1 = tb_bucket(sva, coe_a[127:64], coe_b[127:64]);
            case ($urandom_range(0, 4))
                0: begin tbl_key[0][i0] = sva; tbl_occ[0][i0] = 1'b1; end
                1: begin tbl_key[1][i1] = sva; tbl_occ[1][i1] = 1'b1; end
                2: begin
                    tbl_key[0][i0] = sva; tbl_occ[0][i0] = 1'b1;
                    tbl_key[1][i1] = sva; tbl_occ[1][i1] = 1'b1;
                end
                3: begin
                    tbl_key[0][i0] = sva; tbl_occ[0][i0] = 1'b0;
                    tbl_key[1][i1] = sva;
                end
                default: ;
            endcase
            apply_stimulus(sva, 1'b0);
            wait_idle();
        end
        ready_policy = 0;
        repeat (3) @(negedge clk);

        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        check_output("reads_drained", 64'(rdq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
